// File: rtl/command_parse_and_encapsulate_mcgc.sv
// Fixed-address command decoder for CH_NUM gate-control-list RAMs with read-response pipeline.
// Optional macro QGC_RD_ERR_RESP_EN: out-of-window fixed reads return an error response word.
module command_parse_and_encapsulate_mcgc #(
    parameter int ADDR_W    = 19,
    parameter int RAM_AW    = 10,
    parameter int RAM_DW    = 8,
    parameter int CH_NUM    = 2,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [ADDR_W-1:0]          iv_addr,
    input  logic                       i_addr_fixed,
    input  logic [31:0]                iv_wdata,
    input  logic                       i_wr,
    input  logic                       i_rd,
    output logic                       o_wr,
    output logic [ADDR_W-1:0]          ov_addr,
    output logic                       o_addr_fixed,
    output logic [31:0]                ov_rdata,
    output logic [RAM_AW-1:0]          ov_ram_addr,
    output logic [RAM_DW-1:0]          ov_ram_wdata,
    output logic [CH_NUM-1:0]          ov_ram_wr,
    output logic [CH_NUM-1:0]          ov_ram_rd,
    input  logic [CH_NUM*RAM_DW-1:0]   iv_ram_rdata,
    output logic [15:0]                ov_drop_cnt
);

    localparam int CH_W = (CH_NUM > 1) ? $clog2(CH_NUM) : 1;
    localparam int PL   = RD_LAT + 1;
    localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W:0]   WIN  = (ADDR_W+1)'(CH_NUM) << RAM_AW;
`ifdef QGC_RD_ERR_RESP_EN
    localparam logic [31:0] ERR_WORD = 32'hDEAD_0BAD;
`endif

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [ADDR_W-1:0] w_off;
    logic              w_in_win;
    logic              w_hit;
    logic              w_hit_wr;
    logic              w_hit_rd;
    logic              w_drop;
    logic              w_issue;
    logic [CH_W-1:0]   w_ch;
    logic [CH_NUM-1:0] w_onehot;
    logic [RAM_DW-1:0] w_slice;
    logic [31:0]       w_resp;
    logic              w_unused;

    logic              r_iss_vld;
    logic [CH_W-1:0]   r_iss_ch;
    logic [ADDR_W-1:0] r_iss_addr;
    logic              r_vld_p  [PL];
    logic [CH_W-1:0]   r_ch_p   [PL];
    logic [ADDR_W-1:0] r_addr_p [PL];
`ifdef QGC_RD_ERR_RESP_EN
    logic              w_err_rd;
    logic              r_iss_err;
    logic              r_err_p  [PL];
`endif

    assign w_off    = iv_addr - BASE;
    assign w_in_win = (iv_addr >= BASE) && ({1'b0, w_off} < WIN);
    assign w_hit    = i_addr_fixed && w_in_win;
    assign w_ch     = w_off[RAM_AW +: CH_W];
    assign w_hit_wr = i_wr && w_hit;
    assign w_hit_rd = i_rd && !i_wr && w_hit;
    // A read coinciding with a write is lost even when both would hit.
    assign w_drop   = ((i_wr || i_rd) && !w_hit) || (i_wr && i_rd);
    assign w_unused = ^{iv_wdata, w_off};

`ifdef QGC_RD_ERR_RESP_EN
    assign w_err_rd = i_rd && !i_wr && i_addr_fixed && !w_in_win;
    assign w_issue  = w_hit_rd || w_err_rd;
`else
    assign w_issue  = w_hit_rd;
`endif

    always_comb begin
        w_onehot       = '0;
        w_onehot[w_ch] = 1'b1;
    end

    assign w_slice = iv_ram_rdata[r_ch_p[PL-1]*RAM_DW +: RAM_DW];

    always_comb begin
        w_resp              = '0;
        w_resp[RAM_DW-1:0]  = w_slice;
`ifdef QGC_RD_ERR_RESP_EN
        if (r_err_p[PL-1]) begin
            w_resp = ERR_WORD;
        end
`endif
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ov_ram_wr    <= '0;
            ov_ram_rd    <= '0;
            ov_ram_addr  <= '0;
            ov_ram_wdata <= '0;
            ov_drop_cnt  <= '0;
            r_iss_vld    <= 1'b0;
            for (int i = 0; i < PL; i++) begin
                r_vld_p[i] <= 1'b0;
            end
            o_wr         <= 1'b0;
            o_addr_fixed <= 1'b0;
            ov_addr      <= '0;
            ov_rdata     <= '0;
        end else begin
            // Issue stage: RAM strobes one cycle after the command.
            ov_ram_wr    <= w_hit_wr ? w_onehot : '0;
            ov_ram_rd    <= w_hit_rd ? w_onehot : '0;
            ov_ram_addr  <= (w_hit_wr || w_hit_rd) ? w_off[RAM_AW-1:0] : '0;
            ov_ram_wdata <= w_hit_wr ? iv_wdata[RAM_DW-1:0] : '0;
            if (w_drop) begin
                ov_drop_cnt <= sat_inc(ov_drop_cnt);
            end
            r_iss_vld    <= w_issue;
            // Read-latency pipeline.
            r_vld_p[0]   <= r_iss_vld;
            for (int i = 1; i < PL; i++) begin
                r_vld_p[i] <= r_vld_p[i-1];
            end
            // Response stage: capture the selected channel's RAM data.
            o_wr         <= r_vld_p[PL-1];
            o_addr_fixed <= r_vld_p[PL-1];
            ov_addr      <= r_vld_p[PL-1] ? r_addr_p[PL-1] : '0;
            ov_rdata     <= r_vld_p[PL-1] ? w_resp : '0;
        end
    end

    always_ff @(posedge i_clk) begin
        r_iss_ch    <= w_ch;
        r_iss_addr  <= iv_addr;
        r_ch_p[0]   <= r_iss_ch;
        r_addr_p[0] <= r_iss_addr;
        for (int i = 1; i < PL; i++) begin
            r_ch_p[i]   <= r_ch_p[i-1];
            r_addr_p[i] <= r_addr_p[i-1];
        end
`ifdef QGC_RD_ERR_RESP_EN
        r_iss_err  <= w_err_rd;
        r_err_p[0] <= r_iss_err;
        for (int i = 1; i < PL; i++) begin
            r_err_p[i] <= r_err_p[i-1];
        end
`endif
    end

endmodule

// File: tb/tb_command_parse_and_encapsulate_mcgc.sv
// Directed bench for command_parse_and_encapsulate_mcgc with a 2-channel latency-modelled RAM.
module tb_command_parse_and_encapsulate_mcgc;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic [18:0] iv_addr;
    logic        i_addr_fixed;
    logic [31:0] iv_wdata;
    logic        i_wr;
    logic        i_rd;
    logic        o_wr;
    logic [18:0] ov_addr;
    logic        o_addr_fixed;
    logic [31:0] ov_rdata;
    logic [9:0]  ov_ram_addr;
    logic [7:0]  ov_ram_wdata;
    logic [1:0]  ov_ram_wr;
    logic [1:0]  ov_ram_rd;
    logic [15:0] iv_ram_rdata;
    logic [15:0] ov_drop_cnt;

    int total = 0;
    int bad   = 0;

    always #5 i_clk = ~i_clk;

    command_parse_and_encapsulate_mcgc dut (
        .i_clk        (i_clk),
        .i_rst_n      (i_rst_n),
        .iv_addr      (iv_addr),
        .i_addr_fixed (i_addr_fixed),
        .iv_wdata     (iv_wdata),
        .i_wr         (i_wr),
        .i_rd         (i_rd),
        .o_wr         (o_wr),
        .ov_addr      (ov_addr),
        .o_addr_fixed (o_addr_fixed),
        .ov_rdata     (ov_rdata),
        .ov_ram_addr  (ov_ram_addr),
        .ov_ram_wdata (ov_ram_wdata),
        .ov_ram_wr    (ov_ram_wr),
        .ov_ram_rd    (ov_ram_rd),
        .iv_ram_rdata (iv_ram_rdata),
        .ov_drop_cnt  (ov_drop_cnt)
    );

    // RAM contents: data for a strobe in cycle 1 is presented during cycle 4.
    function automatic logic [7:0] mem_rd(input int c, input logic [9:0] a);
        if (c == 0) begin
            case (a)
                10'd0:   return 8'h11;
                10'd1:   return 8'h22;
                default: return 8'h00;
            endcase
        end else begin
            case (a)
                10'd0:   return 8'h33;
                10'd1:   return 8'h44;
                10'd3:   return 8'h3C;
                default: return 8'h00;
            endcase
        end
    endfunction

    logic [7:0] q0 [2];
    logic [7:0] q1 [2];
    logic [7:0] q2 [2];

    always_ff @(posedge i_clk) begin
        for (int c = 0; c < 2; c++) begin
            q0[c] <= ov_ram_rd[c] ? mem_rd(c, ov_ram_addr) : 8'hEE;
            q1[c] <= q0[c];
            q2[c] <= q1[c];
        end
    end

    assign iv_ram_rdata = {q2[1], q2[0]};

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmd(input logic wr, input logic rd, input logic fx,
                       input logic [18:0] a, input logic [31:0] d);
        i_wr = wr; i_rd = rd; i_addr_fixed = fx; iv_addr = a; iv_wdata = d;
    endtask

    task automatic idle();
        cmd(1'b0, 1'b0, 1'b0, 19'd0, 32'd0);
    endtask

    task automatic chk_resp(input string tag, input logic [18:0] a, input logic [31:0] d);
        chk({tag, "_owr"}, {31'd0, o_wr}, 32'd1);
        chk({tag, "_fix"}, {31'd0, o_addr_fixed}, 32'd1);
        chk({tag, "_addr"}, {13'd0, ov_addr}, {13'd0, a});
        chk({tag, "_data"}, ov_rdata, d);
    endtask

    initial begin
        i_rst_n = 1'b0;
        idle();
        repeat (3) step();
        chk("rst_owr", {31'd0, o_wr}, 32'd0);
        chk("rst_ramwr", {30'd0, ov_ram_wr}, 32'd0);
        chk("rst_ramrd", {30'd0, ov_ram_rd}, 32'd0);
        chk("rst_drop", {16'd0, ov_drop_cnt}, 32'd0);
        chk("rst_rdata", ov_rdata, 32'd0);
        i_rst_n = 1'b1;
        repeat (2) step();

        // Hit write to channel 0
        cmd(1'b1, 1'b0, 1'b1, 19'h005, 32'h0000_005A);
        step();
        idle();
        chk("wr_strobe", {30'd0, ov_ram_wr}, 32'h1);
        chk("wr_addr", {22'd0, ov_ram_addr}, 32'h5);
        chk("wr_data", {24'd0, ov_ram_wdata}, 32'h5A);
        chk("wr_nord", {30'd0, ov_ram_rd}, 32'h0);
        chk("wr_drop", {16'd0, ov_drop_cnt}, 32'd0);
        step();
        chk("wr_clear", {30'd0, ov_ram_wr}, 32'h0);
        chk("wr_addr_clear", {22'd0, ov_ram_addr}, 32'h0);

        // Read from channel 1, latency check
        cmd(1'b0, 1'b1, 1'b1, 19'h403, 32'hFFFF_FFFF);
        step();
        idle();
        chk("rd_strobe", {30'd0, ov_ram_rd}, 32'h2);
        chk("rd_addr", {22'd0, ov_ram_addr}, 32'h3);
        chk("rd_wdata", {24'd0, ov_ram_wdata}, 32'h0);
        repeat (3) step();
        chk("rd_early", {31'd0, o_wr}, 32'd0);
        step();
        chk_resp("rd1", 19'h403, 32'h0000_003C);
        step();
        chk("rd_after", {31'd0, o_wr}, 32'd0);
        chk("rd_after_data", ov_rdata, 32'd0);

        // Back-to-back reads alternating channels
        cmd(1'b0, 1'b1, 1'b1, 19'h000, 32'd0); step();
        cmd(1'b0, 1'b1, 1'b1, 19'h400, 32'd0); step();
        cmd(1'b0, 1'b1, 1'b1, 19'h001, 32'd0); step();
        cmd(1'b0, 1'b1, 1'b1, 19'h401, 32'd0); step();
        idle();
        step();
        chk_resp("b2b0", 19'h000, 32'h11);
        step();
        chk_resp("b2b1", 19'h400, 32'h33);
        step();
        chk_resp("b2b2", 19'h001, 32'h22);
        step();
        chk_resp("b2b3", 19'h401, 32'h44);
        step();
        chk("b2b_end", {31'd0, o_wr}, 32'd0);

        // Simultaneous write and read: write wins, read dropped
        cmd(1'b1, 1'b1, 1'b1, 19'h010, 32'h0000_0077);
        step();
        idle();
        chk("wrrd_wr", {30'd0, ov_ram_wr}, 32'h1);
        chk("wrrd_rd", {30'd0, ov_ram_rd}, 32'h0);
        chk("wrrd_addr", {22'd0, ov_ram_addr}, 32'h10);
        chk("wrrd_drop", {16'd0, ov_drop_cnt}, 32'd1);
        for (int i = 0; i < 6; i++) begin
            step();
            chk("wrrd_noresp", {31'd0, o_wr}, 32'd0);
        end

        // Out-of-window read
        cmd(1'b0, 1'b1, 1'b1, 19'h800, 32'd0);
        step();
        idle();
        chk("oow_rd", {30'd0, ov_ram_rd}, 32'h0);
        chk("oow_drop", {16'd0, ov_drop_cnt}, 32'd2);
        repeat (4) step();
`ifdef QGC_RD_ERR_RESP_EN
        chk_resp("oow_err", 19'h800, 32'hDEAD_0BAD);
`else
        chk("oow_noresp", {31'd0, o_wr}, 32'd0);
`endif
        step();
        chk("oow_after", {31'd0, o_wr}, 32'd0);

        // Non-fixed-address read is ignored and counted
        cmd(1'b0, 1'b1, 1'b0, 19'h005, 32'd0);
        step();
        idle();
        chk("nofix_rd", {30'd0, ov_ram_rd}, 32'h0);
        chk("nofix_drop", {16'd0, ov_drop_cnt}, 32'd3);
        for (int i = 0; i < 5; i++) begin
            step();
            chk("nofix_noresp", {31'd0, o_wr}, 32'd0);
        end

        // Reset while a read is in flight
        cmd(1'b0, 1'b1, 1'b1, 19'h001, 32'd0);
        step();
        idle();
        chk("mid_rd", {30'd0, ov_ram_rd}, 32'h1);
        step();
        i_rst_n = 1'b0;
        #1;
        chk("mid_rst_drop", {16'd0, ov_drop_cnt}, 32'd0);
        chk("mid_rst_rd", {30'd0, ov_ram_rd}, 32'h0);
        chk("mid_rst_addr", {22'd0, ov_ram_addr}, 32'h0);
        step();
        i_rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            step();
            chk("mid_noresp", {31'd0, o_wr}, 32'd0);
            chk("mid_rdata", ov_rdata, 32'd0);
        end
        chk("mid_drop_end", {16'd0, ov_drop_cnt}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
